i2s_rx_sync: RTL and testbench

Parametrised I2S/left-justified audio receiver for the PCM1808 ADC path. It runs entirely in the system clock domain: `sck`, `ws` and `sd` are oversampled through synchronisers, and serial clock edges are detected as enable events. Word width and frame format are selectable. The block outputs a stereo sample pair with a one-cycle `valid` strobe, which downstream audio buffering consumes directly without crossing clock domains.

---
 rtl/i2s_rx_sync_if.sv | 23 ++
 rtl/i2s_rx_sync.sv | 144 ++++++++++++++
 tb/tb_i2s_rx_sync.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_sync_if.sv
// I2S receiver bus: serial pins in, stereo sample pair out.
// master = receiver side; slave = source/consumer side.
interface i2s_rx_sync_if #(
  parameter int DATA_W = 16
);
  logic              sck;
  logic              ws;
  logic              sd;
  logic [DATA_W-1:0] data_l;
  logic [DATA_W-1:0] data_r;
  logic              valid;
  logic              err;

  modport master (
    input  sck, ws, sd,
    output data_l, data_r, valid, err
  );

  modport slave (
    output sck, ws, sd,
    input  data_l, data_r, valid, err
  );
endinterface

// File: rtl/i2s_rx_sync.sv
// Oversampled I2S / left-justified receiver, clk domain only.
// Ports: clk, rst (sync, high), bus (sck/ws/sd in; data_l/data_r/valid/err out).
// Optional I2S_RX_ERR_EN builds short-word detection on err.
module i2s_rx_sync #(
  parameter int DATA_W      = 16,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  i2s_rx_sync_if.master bus
);

  localparam int OFF  = (MODE == 1) ? 0 : 1;
  localparam int LAST = OFF + DATA_W - 1;

  typedef enum logic [1:0] {
    UNLOCKED,
    GOT_LEFT,
    RUN
  } state_t;

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] ws_q;
  logic [SYNC_STAGES-1:0] sd_q;
  logic                   sck_h;
  logic                   ws_prev;
  logic [5:0]             idx;
  logic [DATA_W-1:0]      shreg;
  logic [DATA_W-1:0]      hold_l;
  logic [DATA_W-1:0]      data_l_q;
  logic [DATA_W-1:0]      data_r_q;
  logic                   valid_q;
  state_t                 state;

  logic              sck_s;
  logic              ws_s;
  logic              sd_s;
  logic              bit_ev;
  logic              bound;
  logic [5:0]        idx_n;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] shreg_n;

  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign ws_s   = ws_q[SYNC_STAGES-1];
  assign sd_s   = sd_q[SYNC_STAGES-1];
  assign bit_ev = sck_s & ~sck_h;
  assign bound  = bit_ev & (ws_s != ws_prev);

  always_comb begin
    if (bound)
      idx_n = 6'd0;
    else if (idx == 6'd63)
      idx_n = idx;
    else
      idx_n = idx + 6'd1;
  end

  // Bits land at their final left-aligned position, so
  // a short word is already zero-filled in the LSBs.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DATA_W; i++)
      if (idx_n == 6'(LAST - i))
        mask[i] = 1'b1;
  end

  always_comb begin
    base    = bound ? '0 : shreg;
    shreg_n = (base & ~mask) | (sd_s ? mask : '0);
  end

`ifdef I2S_RX_ERR_EN
  logic err_q;
  logic short_w;

  assign short_w = (idx < 6'(LAST));
  assign bus.err = err_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else
      err_q <= bound && (state != UNLOCKED)
               && short_w;
  end
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q    <= '0;
      ws_q     <= '0;
      sd_q     <= '0;
      sck_h    <= 1'b0;
      ws_prev  <= 1'b0;
      idx      <= '0;
      shreg    <= '0;
      hold_l   <= '0;
      data_l_q <= '0;
      data_r_q <= '0;
      valid_q  <= 1'b0;
      state    <= UNLOCKED;
    end else begin
      sck_q   <= {sck_q[SYNC_STAGES-2:0], bus.sck};
      ws_q    <= {ws_q[SYNC_STAGES-2:0], bus.ws};
      sd_q    <= {sd_q[SYNC_STAGES-2:0], bus.sd};
      sck_h   <= sck_s;
      valid_q <= 1'b0;
      if (bit_ev) begin
        ws_prev <= ws_s;
        idx     <= idx_n;
        shreg   <= shreg_n;
      end
      if (bound) begin
        unique case (state)
          UNLOCKED: begin
            if (!ws_s)
              state <= GOT_LEFT;
          end
          GOT_LEFT, RUN: begin
            if (!ws_prev) begin
              hold_l <= shreg;
            end else begin
              data_l_q <= hold_l;
              data_r_q <= shreg;
              valid_q  <= 1'b1;
              state    <= RUN;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

  assign bus.data_l = data_l_q;
  assign bus.data_r = data_r_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_i2s_rx_sync.sv
// Scoreboard bench for i2s_rx_sync: three configurations.
// Directed frames push expected pairs; monitors pop on valid.
module tb_i2s_rx_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_d = 1'b1;
  logic [2:0] sck_p = '0;
  logic [2:0] ws_p = '0;
  logic [2:0] sd_p = '0;

  int checks = 0;
  int errors = 0;
  int err_cnt [3];
  int exp_err [3];
  logic vprev [3];
  logic [31:0] last_l [3];
  logic [31:0] last_r [3];
  logic [63:0] q [3][$];

  always #5 clk = ~clk;

  i2s_rx_sync_if #(.DATA_W(16)) b0 ();
  i2s_rx_sync_if #(.DATA_W(16)) b1 ();
  i2s_rx_sync_if #(.DATA_W(24)) b2 ();

  assign b0.sck = sck_p[0];
  assign b0.ws  = ws_p[0];
  assign b0.sd  = sd_p[0];
  assign b1.sck = sck_p[1];
  assign b1.ws  = ws_p[1];
  assign b1.sd  = sd_p[1];
  assign b2.sck = sck_p[2];
  assign b2.ws  = ws_p[2];
  assign b2.sd  = sd_p[2];

  i2s_rx_sync #(.DATA_W(16), .MODE(0), .SYNC_STAGES(2))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  i2s_rx_sync #(.DATA_W(16), .MODE(1), .SYNC_STAGES(3))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  i2s_rx_sync #(.DATA_W(24), .MODE(0), .SYNC_STAGES(2))
    u2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic mon(input int s, input logic v,
                     input logic e, input logic [31:0] l,
                     input logic [31:0] r);
    logic [63:0] x;
    if (e) err_cnt[s]++;
    if (v) begin
      checks++;
      if (vprev[s]) begin
        errors++;
        $display("FAIL valid_width dut%0d: high 2 cycles", s);
      end
      checks++;
      if (q[s].size() == 0) begin
        errors++;
        $display("FAIL extra_valid dut%0d: got %h/%h, none expected",
                 s, l, r);
      end else begin
        x = q[s].pop_front();
        if ({l, r} !== x) begin
          errors++;
          $display("FAIL pair dut%0d: got %h/%h want %h/%h",
                   s, l, r, x[63:32], x[31:0]);
        end
      end
    end else if (!rst && !rst_d) begin
      checks++;
      if (l !== last_l[s] || r !== last_r[s]) begin
        errors++;
        $display("FAIL stable dut%0d: got %h/%h want %h/%h",
                 s, l, r, last_l[s], last_r[s]);
      end
    end
    vprev[s] = v;
    last_l[s] = l;
    last_r[s] = r;
  endtask

  always @(negedge clk) begin
    mon(0, b0.valid, b0.err, 32'(b0.data_l), 32'(b0.data_r));
    mon(1, b1.valid, b1.err, 32'(b1.data_l), 32'(b1.data_r));
    mon(2, b2.valid, b2.err, 32'(b2.data_l), 32'(b2.data_r));
    rst_d = rst;
  end

  // One sck period = 8 clk; data changes while sck is low.
  task automatic send_bits(input int s, input logic w,
                           input logic [31:0] v, input int nb,
                           input bit lj, input int k0,
                           input int k1);
    for (int k = k0; k <= k1; k++) begin
      int j;
      j = lj ? k : k - 1;
      ws_p[s] = w;
      sd_p[s] = (j >= 0 && j < nb) ? v[nb-1-j] : 1'b0;
      sck_p[s] = 1'b0;
      repeat (4) @(negedge clk);
      sck_p[s] = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic frame(input int s, input logic [31:0] l,
                       input logic [31:0] r, input int nb,
                       input int slot, input bit lj);
    send_bits(s, 1'b0, l, nb, lj, 0, slot - 1);
    send_bits(s, 1'b1, r, nb, lj, 0, slot - 1);
  endtask

  task automatic expect_pair(input int s, input logic [31:0] l,
                             input logic [31:0] r);
    q[s].push_back({l, r});
  endtask

  task automatic do_reset();
    sck_p = '0;
    ws_p = '0;
    sd_p = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Reset, then a partial right word so the stream starts mid-right.
  task automatic start(input int s);
    do_reset();
    send_bits(s, 1'b1, 32'h1F, 5, 1'b1, 0, 4);
  endtask

  // One bit into the next left word to commit the last right word.
  task automatic stop(input int s);
    send_bits(s, 1'b0, 32'h0, 1, 1'b1, 0, 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, b);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      err_cnt[i] = 0;
      exp_err[i] = 0;
      vprev[i] = 1'b0;
      last_l[i] = '0;
      last_r[i] = '0;
    end
    do_reset();
    chk("rst_l0", 32'(b0.data_l), 32'h0);
    chk("rst_r0", 32'(b0.data_r), 32'h0);
    chk("rst_v0", 32'(b0.valid), 32'h0);
    chk("rst_e0", 32'(b0.err), 32'h0);
    chk("rst_l2", 32'(b2.data_l), 32'h0);
    chk("rst_v1", 32'(b1.valid), 32'h0);

    start(0);
    frame(0, 32'h1234, 32'hABCD, 16, 32, 1'b0);
    expect_pair(0, 32'h1234, 32'hABCD);
    frame(0, 32'h5A5A, 32'h0F0F, 16, 32, 1'b0);
    expect_pair(0, 32'h5A5A, 32'h0F0F);
    stop(0);

    start(1);
    frame(1, 32'h1234, 32'hABCD, 16, 32, 1'b1);
    expect_pair(1, 32'h1234, 32'hABCD);
    frame(1, 32'hFFFF, 32'h0001, 16, 32, 1'b1);
    expect_pair(1, 32'hFFFF, 32'h0001);
    stop(1);

    start(1);
    frame(1, 32'h1234, 32'hABCD, 16, 32, 1'b0);
    expect_pair(1, 32'h091A, 32'h55E6);
    stop(1);

    start(2);
    frame(2, 32'h800001, 32'h7FFFFE, 24, 32, 1'b0);
    expect_pair(2, 32'h800001, 32'h7FFFFE);
    stop(2);

    start(0);
    frame(0, 32'hA5, 32'h3C, 8, 8, 1'b0);
    expect_pair(0, 32'hA400, 32'h3C00);
    stop(0);

    start(1);
    frame(1, 32'hA5, 32'h3C, 8, 8, 1'b1);
    expect_pair(1, 32'hA500, 32'h3C00);
    stop(1);
`ifdef I2S_RX_ERR_EN
    exp_err[0] = 2;
    exp_err[1] = 2;
`endif

    start(0);
    frame(0, 32'h1111, 32'h2222, 16, 32, 1'b0);
    expect_pair(0, 32'h1111, 32'h2222);
    send_bits(0, 1'b0, 32'h6666, 16, 1'b0, 0, 9);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_l", 32'(b0.data_l), 32'h0);
    chk("mid_rst_r", 32'(b0.data_r), 32'h0);
    chk("mid_rst_v", 32'(b0.valid), 32'h0);
    chk("mid_rst_e", 32'(b0.err), 32'h0);
    rst = 1'b0;
    send_bits(0, 1'b0, 32'h6666, 16, 1'b0, 10, 31);
    send_bits(0, 1'b1, 32'h7777, 16, 1'b0, 0, 31);
    frame(0, 32'h4444, 32'h5555, 16, 32, 1'b0);
    expect_pair(0, 32'h4444, 32'h5555);
    stop(0);

    for (int s = 0; s < 3; s++) begin
      checks++;
      if (q[s].size() != 0) begin
        errors++;
        $display("FAIL missing_valid dut%0d: %0d pending, want 0",
                 s, q[s].size());
      end
      checks++;
      if (err_cnt[s] != exp_err[s]) begin
        errors++;
        $display("FAIL err_count dut%0d: got %0d want %0d",
                 s, err_cnt[s], exp_err[s]);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
